// File: rtl/prog_loader_pkg.sv
// Shared types and frame-layout constants for the byte-stream program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_W_LO,
    ST_W_HI,
    ST_CSUM
  } state_t;

  localparam logic [7:0] START_BYTE_DEF = 8'hA5;
  localparam int         MAX_WORDS_DEF  = 1024;
  localparam int         BYTE_W         = 8;
  localparam int         CNT_W          = 11;  // word count / words_loaded width
  localparam int         CNT_HI_BITS    = 3;   // count bits carried in CNT_HI
  localparam int         WHI_BITS       = 2;   // word bits carried in W_HI

endpackage

// File: rtl/prog_loader.sv
// Receives a framed program image byte by byte, writes 10-bit words into
// instruction memory from address 0 and releases the CPU on a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter int         DATA_W     = 10,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter int         MAX_WORDS  = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_t            state_reg, state_next;
  logic [BYTE_W-1:0] cnt_lo_reg, cnt_lo_next;
  logic [CNT_W-1:0]  n_reg, n_next;
  logic [BYTE_W-1:0] w_lo_reg, w_lo_next;
  logic [BYTE_W-1:0] csum_reg, csum_next;
  logic [CNT_W-1:0]  words_reg, words_next;
  logic              ready_reg;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              hold_reg, hold_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic              xfer;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  words_inc;

  assign xfer      = in_valid & ready_reg;
  assign n_in      = {in_data[CNT_HI_BITS-1:0], cnt_lo_reg};
  assign words_inc = words_reg + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_lo_reg <= '0;
      n_reg      <= '0;
      w_lo_reg   <= '0;
      csum_reg   <= '0;
      words_reg  <= '0;
      ready_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      hold_reg   <= 1'b1;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_lo_reg <= cnt_lo_next;
      n_reg      <= n_next;
      w_lo_reg   <= w_lo_next;
      csum_reg   <= csum_next;
      words_reg  <= words_next;
      ready_reg  <= 1'b1;  // never back-pressures once out of reset
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      hold_reg   <= hold_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_lo_next = cnt_lo_reg;
    n_next      = n_reg;
    w_lo_next   = w_lo_reg;
    csum_next   = csum_reg;
    words_next  = words_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    hold_next   = hold_reg;
    done_next   = done_reg;
    err_next    = err_reg;

    if (xfer) begin
      // Every byte between the start marker and the checksum byte is summed.
      if (state_reg != ST_IDLE && state_reg != ST_CSUM)
        csum_next = csum_reg + in_data;

      case (state_reg)
        ST_IDLE: begin
          if (in_data == START_BYTE) begin
            state_next = ST_CNT_LO;
            done_next  = 1'b0;
            err_next   = 1'b0;
            words_next = '0;
            csum_next  = '0;
            hold_next  = 1'b1;
          end
        end
        ST_CNT_LO: begin
          cnt_lo_next = in_data;
          state_next  = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          n_next = n_in;
          if (in_data[BYTE_W-1:CNT_HI_BITS] != '0 || n_in > MAX_N) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else if (n_in == '0) begin
            state_next = ST_CSUM;
          end else begin
            state_next = ST_W_LO;
          end
        end
        ST_W_LO: begin
          w_lo_next  = in_data;
          state_next = ST_W_HI;
        end
        ST_W_HI: begin
          if (in_data[BYTE_W-1:WHI_BITS] != '0) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            we_next    = 1'b1;
            addr_next  = words_reg[ADDR_W-1:0];
            wdata_next = DATA_W'({in_data[WHI_BITS-1:0], w_lo_reg});
            words_next = words_inc;
            state_next = (words_inc == n_reg) ? ST_CSUM : ST_W_LO;
          end
        end
        ST_CSUM: begin
          if (in_data == csum_reg) begin
            done_next = 1'b1;
            hold_next = 1'b0;
          end else begin
            err_next  = 1'b1;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign in_ready     = ready_reg;
  assign imem_we      = we_reg;
  assign imem_addr    = addr_reg;
  assign imem_wdata   = wdata_reg;
  assign cpu_hold     = hold_reg;
  assign load_done    = done_reg;
  assign load_err     = err_reg;
  assign words_loaded = words_reg;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the 10-bit CPU: receives a framed image over a valid/ready byte interface, assembles 10-bit instruction words and writes them sequentially into instruction memory from address 0. Holds the CPU in reset until a frame has loaded with a correct checksum. Sits between the host link (UART/JTAG byte bridge) and the instruction-memory write port, beside the CPU core that reads that memory through its fetch path.

## Interface
- ADDR_W, 10, instruction-memory address width
- DATA_W, 10, instruction word width
- START_BYTE, 8'hA5, frame start marker
- MAX_WORDS, 1024, largest legal word count (2**ADDR_W)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- in_data  in  8  received byte
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  loader accepts a byte; transfer = in_valid & in_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_hold  out  1  drives the CPU's rst; 1 = CPU held
- load_done  out  1  sticky: last frame loaded, checksum OK
- load_err  out  1  sticky: last frame aborted or checksum bad
- words_loaded  out  11  words written by current/last frame

## Operation
- Frame: START_BYTE, CNT_LO, CNT_HI, N × (W_LO, W_HI), CSUM. N = {CNT_HI[2:0], CNT_LO}; word = {W_HI[1:0], W_LO}.
- States: IDLE, CNT_LO, CNT_HI, W_LO, W_HI, CSUM.
- IDLE: bytes ≠ START_BYTE discarded. START_BYTE → CNT_LO; clears load_done, load_err, words_loaded, checksum accumulator; sets cpu_hold=1.
- CNT_LO → CNT_HI. CNT_HI: N > MAX_WORDS or CNT_HI[7:3] ≠ 0 → load_err=1, IDLE; N = 0 → CSUM; else W_LO.
- W_LO → W_HI. W_HI: W_HI[7:2] ≠ 0 → load_err=1, IDLE, no write; else write word, words_loaded+1; → CSUM if words_loaded+1 == N, else W_LO.
- Checksum: 8-bit mod-256 sum of every byte after START_BYTE up to but excluding CSUM.
- CSUM: match → load_done=1, cpu_hold=0, IDLE; mismatch → load_err=1, cpu_hold stays 1, IDLE.
- START_BYTE received inside a frame is data, not a restart.
- Address = words_loaded[ADDR_W-1:0]; always starts at 0; no wrap (bounded by MAX_WORDS check).

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0, state IDLE.
- in_ready=1 every cycle after the first clk edge following rst deassertion; loader never back-pressures (max one byte/cycle).
- All outputs registered. imem_we/addr/wdata valid the cycle after the W_HI transfer; imem_we high exactly one cycle.
- load_done, cpu_hold deassertion and load_err update the cycle after the deciding transfer.
- in_valid gaps of any length allowed between bytes; no timeout.
- rst mid-frame: immediate return to reset values; partially written memory left as is; cpu_hold=1.

## Structure
- prog_loader_pkg: state enum, START_BYTE default, MAX_WORDS, frame-field widths.
- Single module; no sub-module (FSM, word counter, checksum accumulator are small).

## Test plan
- Reset: hold rst 3 cycles → all outputs at reset values; in_ready=1 one cycle after release.
- Good frame A5,02,00,34,01,FF,03,39 → writes 0x134@0, 0x3FF@1, each one-cycle imem_we; then load_done=1, cpu_hold=0, words_loaded=2.
- Same frame with CSUM=3A → both writes occur, load_err=1, load_done=0, cpu_hold=1.
- Garbage 00,FF,5A, then A5,00,00,00 with random in_valid gaps → no writes, load_done=1, cpu_hold=0.
- A5,01,04 (N=1025) → load_err=1 after CNT_HI, no writes; next valid frame loads normally and clears load_err.
- Assert rst after first word of a 3-word frame → cpu_hold=1, words_loaded=0, no further writes; new frame then loads from address 0.
